// File: rtl/alu_seq_if.sv
// Request/response bundle for alu_seq: operands and opcode in, registered
// results and busy/done status out.
interface alu_seq_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [2:0]       alucont;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] hi;
    logic             zero;
    logic             busy;
    logic             done;

    modport master (
        output start, alucont, a, b,
        input  result, hi, zero, busy, done
    );

    modport slave (
        input  start, alucont, a, b,
        output result, hi, zero, busy, done
    );
endinterface

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/arith ops, WIDTH-cycle shift-add multiply
// and, when ALU_SEQ_DIV_EN is defined, WIDTH-cycle restoring divide.
module alu_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic     clk,
    input  logic     reset_n,
    alu_seq_if.slave bus
);
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_MUL = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;
`ifdef ALU_SEQ_DIV_EN
    localparam logic [2:0] OP_DIV = 3'b100;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;
`else
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_e;
`endif

    state_e             state_q;
    logic [WIDTH-1:0]   result_q;
    logic [WIDTH-1:0]   hi_q;
    logic               zero_q;
    logic               busy_q;
    logic               done_q;
    logic [2*WIDTH-1:0] prod_q;
    logic [WIDTH-1:0]   opnd_q;
    logic [CW-1:0]      cnt_q;

    logic               sub_d;
    logic [WIDTH-1:0]   b_eff_d;
    logic [WIDTH-1:0]   sum_d;
    logic               ovf_d;
    logic               slt_d;
    logic [WIDTH-1:0]   alu_d;
    logic [WIDTH:0]     mul_add_d;
    logic [2*WIDTH-1:0] mul_d;

    assign bus.result = result_q;
    assign bus.hi     = hi_q;
    assign bus.zero   = zero_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;

    // Single-cycle datapath works straight off the bus operands at the capture edge.
    always_comb begin
        sub_d   = (bus.alucont == OP_SUB) || (bus.alucont == OP_SLT);
        b_eff_d = sub_d ? ~bus.b : bus.b;
        sum_d   = bus.a + b_eff_d + WIDTH'(sub_d);
        ovf_d   = (bus.a[WIDTH-1] == b_eff_d[WIDTH-1]) && (sum_d[WIDTH-1] != bus.a[WIDTH-1]);
        slt_d   = sum_d[WIDTH-1] ^ ovf_d;
        case (bus.alucont)
            OP_AND:         alu_d = bus.a & bus.b;
            OP_OR:          alu_d = bus.a | bus.b;
            OP_ADD, OP_SUB: alu_d = sum_d;
            OP_SLT:         alu_d = WIDTH'(slt_d);
            default:        alu_d = '0;
        endcase
    end

    // prod_q holds {partial sum, remaining multiplier bits}; one bit consumed per step.
    always_comb begin
        mul_add_d = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, opnd_q} : '0);
        mul_d     = {mul_add_d, prod_q[WIDTH-1:1]};
    end

`ifdef ALU_SEQ_DIV_EN
    logic [WIDTH:0]     div_shift_d;
    logic [WIDTH:0]     div_trial_d;
    logic               div_ok_d;
    logic [2*WIDTH-1:0] div_d;

    // prod_q holds {remainder, dividend/quotient}; a zero divisor always "fits",
    // which naturally yields quotient all-ones and remainder equal to a.
    always_comb begin
        div_shift_d = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
        div_trial_d = div_shift_d - {1'b0, opnd_q};
        div_ok_d    = ~div_trial_d[WIDTH] || (opnd_q == '0);
        div_d       = div_ok_d ? {div_trial_d[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1}
                               : {div_shift_d[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b0};
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            hi_q     <= '0;
            zero_q   <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            prod_q   <= '0;
            opnd_q   <= '0;
            cnt_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        cnt_q <= '0;
                        case (bus.alucont)
                            OP_MUL: begin
                                prod_q  <= {{WIDTH{1'b0}}, bus.b};
                                opnd_q  <= bus.a;
                                busy_q  <= 1'b1;
                                state_q <= S_MUL;
                            end
`ifdef ALU_SEQ_DIV_EN
                            OP_DIV: begin
                                prod_q  <= {{WIDTH{1'b0}}, bus.a};
                                opnd_q  <= bus.b;
                                busy_q  <= 1'b1;
                                state_q <= S_DIV;
                            end
`endif
                            default: begin
                                result_q <= alu_d;
                                hi_q     <= '0;
                                zero_q   <= (alu_d == '0);
                                done_q   <= 1'b1;
                                state_q  <= S_DONE;
                            end
                        endcase
                    end
                end
                S_MUL: begin
                    prod_q <= mul_d;
                    cnt_q  <= cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        result_q <= mul_d[WIDTH-1:0];
                        hi_q     <= mul_d[2*WIDTH-1:WIDTH];
                        zero_q   <= (mul_d[WIDTH-1:0] == '0);
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= S_DONE;
                    end
                end
`ifdef ALU_SEQ_DIV_EN
                S_DIV: begin
                    prod_q <= div_d;
                    cnt_q  <= cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        result_q <= div_d[WIDTH-1:0];
                        hi_q     <= div_d[2*WIDTH-1:WIDTH];
                        zero_q   <= (div_d[WIDTH-1:0] == '0);
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= S_DONE;
                    end
                end
`endif
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq at WIDTH=8; divide vectors follow
// ALU_SEQ_DIV_EN.
module tb_alu_seq;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    alu_seq_if #(.WIDTH(8)) bus ();

    alu_seq #(.WIDTH(8)) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one request so it is captured at the next rising edge, then look #1 after it.
    task automatic op_start(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        bus.alucont = op;
        bus.a       = a;
        bus.b       = b;
        bus.start   = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic run_single(input string tag, input logic [2:0] op, input logic [7:0] a,
                              input logic [7:0] b, input logic [7:0] er, input logic [7:0] eh,
                              input logic ez);
        op_start(op, a, b);
        bus.a = ~a;
        bus.b = ~b;
        chk({tag, ".done"}, bus.done, 1'b1);
        chk({tag, ".busy"}, bus.busy, 1'b0);
        chk({tag, ".result"}, bus.result, er);
        chk({tag, ".hi"}, bus.hi, eh);
        chk({tag, ".zero"}, bus.zero, ez);
        @(posedge clk);
        #1;
        chk({tag, ".done_drop"}, bus.done, 1'b0);
        chk({tag, ".held"}, bus.result, er);
    endtask

    task automatic run_multi(input string tag, input logic [2:0] op, input logic [7:0] a,
                             input logic [7:0] b, input logic [7:0] er, input logic [7:0] eh,
                             input logic ez);
        int n_busy;
        int n;
        logic overlap;
        n_busy  = 0;
        n       = 0;
        overlap = 1'b0;
        op_start(op, a, b);
        while (bus.done !== 1'b1 && n < 40) begin
            if (bus.busy === 1'b1) n_busy++;
            @(negedge clk);
            bus.start   = n[0];
            bus.alucont = 3'b010;
            bus.a       = bus.a + 8'h13;
            bus.b       = bus.b ^ 8'h5A;
            @(posedge clk);
            #1;
            if (bus.busy === 1'b1 && bus.done === 1'b1) overlap = 1'b1;
            n++;
        end
        bus.start = 1'b0;
        chk({tag, ".done_seen"}, bus.done, 1'b1);
        chk({tag, ".busy_cycles"}, n_busy, 8);
        chk({tag, ".no_overlap"}, overlap, 1'b0);
        chk({tag, ".busy_at_done"}, bus.busy, 1'b0);
        chk({tag, ".result"}, bus.result, er);
        chk({tag, ".hi"}, bus.hi, eh);
        chk({tag, ".zero"}, bus.zero, ez);
        @(posedge clk);
        #1;
        chk({tag, ".done_drop"}, bus.done, 1'b0);
    endtask

    initial begin
        int dones;
        bus.start   = 1'b0;
        bus.alucont = 3'b000;
        bus.a       = '0;
        bus.b       = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst.result", bus.result, 8'h00);
        chk("rst.hi", bus.hi, 8'h00);
        chk("rst.zero", bus.zero, 1'b1);
        chk("rst.busy", bus.busy, 1'b0);
        chk("rst.done", bus.done, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;

        run_single("add7f", 3'b010, 8'h7F, 8'h01, 8'h80, 8'h00, 1'b0);
        run_single("sub55", 3'b110, 8'h05, 8'h05, 8'h00, 8'h00, 1'b1);
        run_single("sub35", 3'b110, 8'h03, 8'h05, 8'hFE, 8'h00, 1'b0);
        run_single("addwrap", 3'b010, 8'hF0, 8'h20, 8'h10, 8'h00, 1'b0);
        run_single("and", 3'b000, 8'hC3, 8'h5A, 8'h42, 8'h00, 1'b0);
        run_single("or", 3'b001, 8'hC3, 8'h5A, 8'hDB, 8'h00, 1'b0);
        run_single("slt_neg", 3'b111, 8'h80, 8'h01, 8'h01, 8'h00, 1'b0);
        run_single("slt_pos", 3'b111, 8'h01, 8'h80, 8'h00, 8'h00, 1'b1);
        run_single("slt_eq", 3'b111, 8'hFF, 8'hFF, 8'h00, 8'h00, 1'b1);
        run_single("rsvd", 3'b101, 8'h12, 8'h34, 8'h00, 8'h00, 1'b1);

        // Held start: IDLE, DONE, IDLE -- the DONE-cycle operands must be ignored.
        @(negedge clk);
        bus.alucont = 3'b010;
        bus.a       = 8'h01;
        bus.b       = 8'h01;
        bus.start   = 1'b1;
        @(posedge clk);
        #1;
        chk("b2b.done1", bus.done, 1'b1);
        chk("b2b.res1", bus.result, 8'h02);
        bus.a = 8'h02;
        @(posedge clk);
        #1;
        chk("b2b.gap", bus.done, 1'b0);
        chk("b2b.gap_res", bus.result, 8'h02);
        @(posedge clk);
        #1;
        chk("b2b.done2", bus.done, 1'b1);
        chk("b2b.res2", bus.result, 8'h03);
        bus.start = 1'b0;
        @(posedge clk);
        #1;

        run_multi("mulff", 3'b011, 8'hFF, 8'hFF, 8'h01, 8'hFE, 1'b0);
        run_multi("mul1234", 3'b011, 8'h12, 8'h34, 8'hA8, 8'h03, 1'b0);
        run_multi("mul0", 3'b011, 8'h00, 8'h37, 8'h00, 8'h00, 1'b1);

`ifdef ALU_SEQ_DIV_EN
        run_multi("div100_7", 3'b100, 8'd100, 8'd7, 8'd14, 8'd2, 1'b0);
        run_multi("div_by0", 3'b100, 8'h55, 8'h00, 8'hFF, 8'h55, 1'b0);
        run_multi("div_small", 3'b100, 8'h03, 8'h09, 8'h00, 8'h03, 1'b1);
`else
        run_single("div_off", 3'b100, 8'd100, 8'd7, 8'h00, 8'h00, 1'b1);
`endif

        // Abort a multiply mid-flight; no done may follow.
        op_start(3'b011, 8'hFF, 8'hFF);
        repeat (3) @(posedge clk);
        #1;
        chk("abort.busy_before", bus.busy, 1'b1);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("abort.busy", bus.busy, 1'b0);
        chk("abort.done", bus.done, 1'b0);
        chk("abort.result", bus.result, 8'h00);
        chk("abort.hi", bus.hi, 8'h00);
        chk("abort.zero", bus.zero, 1'b1);
        @(negedge clk);
        reset_n = 1'b1;
        dones = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) dones++;
        end
        chk("abort.no_done", dones, 0);
        chk("abort.idle_busy", bus.busy, 1'b0);
        run_single("add34", 3'b010, 8'h03, 8'h04, 8'h07, 8'h00, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
